// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction-fetch controller between IF stage and instruction memory
//
// Issues one fetch per PC and stalls IF while that fetch is outstanding.
// The returned word is presented to IF, or buffered while the pipeline is
// stalled. Responses made stale by a redirect are dropped. A saturating
// counter tracks the stall cycles caused by fetching.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   pc_i             current PC from the IF stage
//   pipe_stall_i     downstream hazard stall
//   jump_c_i         redirect (IF loads the jump target on this cycle)
//   imem_req_o       fetch request
//   imem_addr_o      fetch address
//   imem_gnt_i       request accepted
//   imem_rvalid_i    read data valid
//   imem_rdata_i     read data
//   stall_c_o        stall to the IF stage
//   instruction_o    instruction to the IF stage (NOP when none)
//   instr_valid_o    instruction_o carries a fetched word
//   stall_cnt_o      count of fetch-induced stall cycles
module if_fetch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        pipe_stall_i,
  input  logic        jump_c_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        stall_c_o,
  output logic [31:0] instruction_o,
  output logic        instr_valid_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        first_q, first_d;
  logic        disc_q, disc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] stall_cnt_q;
  logic        deliver;
  logic        busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      first_q     <= 1'b0;
      disc_q      <= 1'b0;
      req_addr_q  <= 32'h0;
      buf_q       <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      disc_q     <= disc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
      if (busy && !pipe_stall_i && !jump_c_i && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    disc_d        = disc_q;
    req_addr_d    = req_addr_q;
    buf_d         = buf_q;
    imem_req_o    = 1'b0;
    imem_addr_o   = 32'h0;
    instruction_o = NOP_INSN;
    instr_valid_o = 1'b0;
    deliver       = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        first_d = 1'b1;
      end

      REQ: begin
        // The PC is sampled only on the first cycle; afterwards the latched
        // address is replayed so the request stays stable until granted.
        imem_req_o  = 1'b1;
        imem_addr_o = first_q ? pc_i : req_addr_q;
        req_addr_d  = first_q ? pc_i : req_addr_q;
        first_d     = 1'b0;
        if (jump_c_i)
          disc_d = 1'b1;
        if (imem_gnt_i)
          state_d = WAIT;
      end

      WAIT: begin
        if (imem_rvalid_i) begin
          first_d = 1'b1;
          if (disc_q || jump_c_i) begin
            disc_d  = 1'b0;
            state_d = REQ;
          end else begin
            deliver       = 1'b1;
            instruction_o = imem_rdata_i;
            instr_valid_o = 1'b1;
            if (pipe_stall_i) begin
              buf_d   = imem_rdata_i;
              state_d = HOLD;
            end else begin
              state_d = REQ;
            end
          end
        end else if (jump_c_i) begin
          // The in-flight response still arrives; mark it for dropping.
          disc_d = 1'b1;
        end
      end

      HOLD: begin
        instruction_o = buf_q;
        instr_valid_o = 1'b1;
        if (jump_c_i || !pipe_stall_i) begin
          state_d = REQ;
          first_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q != HOLD) && !deliver;
  // A redirect always drops the stall so IF never misses loading the target.
  assign stall_c_o   = (pipe_stall_i || busy) && !jump_c_i;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        pipe_stall_i;
  logic        jump_c_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_c_o;
  logic [31:0] instruction_o;
  logic        instr_valid_o;
  logic [31:0] stall_cnt_o;

  int checks;
  int errors;

  if_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_i          (pc_i),
    .pipe_stall_i  (pipe_stall_i),
    .jump_c_i      (jump_c_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .stall_c_o     (stall_c_o),
    .instruction_o (instruction_o),
    .instr_valid_o (instr_valid_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req act=%0h exp=0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr act=%0h exp=0", imem_addr_o); end
    checks++; if (stall_c_o !== 1'b1) begin errors++; $display("FAIL rst_stall act=%0h exp=1", stall_c_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid act=%0h exp=0", instr_valid_o); end
    checks++; if (instruction_o !== NOP) begin errors++; $display("FAIL rst_instr act=%0h exp=%0h", instruction_o, NOP); end
    checks++; if (stall_cnt_o !== 32'h0) begin errors++; $display("FAIL rst_cnt act=%0h exp=0", stall_cnt_o); end
    rst_n = 1'b1;
    cyc();
    #1;
    checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL idle_cnt act=%0d exp=1", stall_cnt_o); end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 3; i++) begin
      pc_i = 32'(i * 4);
      imem_gnt_i = 1'b1;
      #1;
      checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL zw_req[%0d] act=%0h exp=1", i, imem_req_o); end
      checks++; if (imem_addr_o !== 32'(i * 4)) begin errors++; $display("FAIL zw_addr[%0d] act=%0h exp=%0h", i, imem_addr_o, i * 4); end
      checks++; if (stall_c_o !== 1'b1) begin errors++; $display("FAIL zw_stall_req[%0d] act=%0h exp=1", i, stall_c_o); end
      cyc();
      imem_gnt_i = 1'b0;
      imem_rvalid_i = 1'b1;
      imem_rdata_i = 32'h0010_0093 + 32'(i);
      #1;
      checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d] act=%0h exp=1", i, instr_valid_o); end
      checks++; if (instruction_o !== 32'h0010_0093 + 32'(i)) begin errors++; $display("FAIL zw_instr[%0d] act=%0h exp=%0h", i, instruction_o, 32'h0010_0093 + 32'(i)); end
      checks++; if (stall_c_o !== 1'b0) begin errors++; $display("FAIL zw_stall_dlv[%0d] act=%0h exp=0", i, stall_c_o); end
      checks++; if (stall_cnt_o !== 32'(2 + i)) begin errors++; $display("FAIL zw_cnt[%0d] act=%0d exp=%0d", i, stall_cnt_o, 2 + i); end
      cyc();
      imem_rvalid_i = 1'b0;
    end
  endtask

  task automatic test_gnt_delay();
    pc_i = 32'h10;
    imem_gnt_i = 1'b0;
    #1;
    checks++; if (imem_addr_o !== 32'h10) begin errors++; $display("FAIL gd_addr0 act=%0h exp=10", imem_addr_o); end
    cyc();
    pc_i = 32'h99;
    for (int k = 0; k < 3; k++) begin
      imem_gnt_i = (k == 2);
      #1;
      checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL gd_req[%0d] act=%0h exp=1", k, imem_req_o); end
      checks++; if (imem_addr_o !== 32'h10) begin errors++; $display("FAIL gd_addr[%0d] act=%0h exp=10", k, imem_addr_o); end
      checks++; if (stall_c_o !== 1'b1) begin errors++; $display("FAIL gd_stall[%0d] act=%0h exp=1", k, stall_c_o); end
      cyc();
    end
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h00a0_0113;
    #1;
    checks++; if (instruction_o !== 32'h00a0_0113) begin errors++; $display("FAIL gd_instr act=%0h exp=00a00113", instruction_o); end
    cyc();
    imem_rvalid_i = 1'b0;
  endtask

  task automatic test_jump_wait();
    pc_i = 32'h20;
    imem_gnt_i = 1'b1;
    cyc();
    imem_gnt_i = 1'b0;
    jump_c_i = 1'b1;
    #1;
    checks++; if (stall_c_o !== 1'b0) begin errors++; $display("FAIL jw_stall act=%0h exp=0", stall_c_o); end
    cyc();
    jump_c_i = 1'b0;
    pc_i = 32'h100;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL jw_valid act=%0h exp=0", instr_valid_o); end
    checks++; if (instruction_o !== NOP) begin errors++; $display("FAIL jw_instr act=%0h exp=%0h", instruction_o, NOP); end
    checks++; if (stall_c_o !== 1'b1) begin errors++; $display("FAIL jw_stall_drop act=%0h exp=1", stall_c_o); end
    cyc();
    imem_rvalid_i = 1'b0;
    #1;
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL jw_addr act=%0h exp=100", imem_addr_o); end
    imem_gnt_i = 1'b1;
    cyc();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    jump_c_i = 1'b1;
    imem_rdata_i = 32'h1111_1111;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL jd_valid act=%0h exp=0", instr_valid_o); end
    checks++; if (instruction_o !== NOP) begin errors++; $display("FAIL jd_instr act=%0h exp=%0h", instruction_o, NOP); end
    cyc();
    imem_rvalid_i = 1'b0;
    jump_c_i = 1'b0;
    pc_i = 32'h300;
    #1;
    checks++; if (imem_addr_o !== 32'h300) begin errors++; $display("FAIL jd_addr act=%0h exp=300", imem_addr_o); end
  endtask

  task automatic test_hold();
    pc_i = 32'h30;
    imem_gnt_i = 1'b1;
    cyc();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h0050_0093;
    pipe_stall_i = 1'b1;
    #1;
    checks++; if (stall_c_o !== 1'b1) begin errors++; $display("FAIL hd_stall_dlv act=%0h exp=1", stall_c_o); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        cyc();
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL hd_req[%0d] act=%0h exp=0", k, imem_req_o); end
      end
      checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL hd_valid[%0d] act=%0h exp=1", k, instr_valid_o); end
      checks++; if (instruction_o !== 32'h0050_0093) begin errors++; $display("FAIL hd_instr[%0d] act=%0h exp=00500093", k, instruction_o); end
    end
    cyc();
    pipe_stall_i = 1'b0;
    #1;
    checks++; if (stall_c_o !== 1'b0) begin errors++; $display("FAIL hd_release act=%0h exp=0", stall_c_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL hd_req_rel act=%0h exp=0", imem_req_o); end
    cyc();
    pc_i = 32'h34;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h34) begin errors++; $display("FAIL hd_next req=%0h addr=%0h exp req=1 addr=34", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_jump_stall();
    imem_gnt_i = 1'b1;
    cyc();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h0000_0033;
    pipe_stall_i = 1'b1;
    cyc();
    imem_rvalid_i = 1'b0;
    jump_c_i = 1'b1;
    #1;
    checks++; if (stall_c_o !== 1'b0) begin errors++; $display("FAIL js_stall act=%0h exp=0", stall_c_o); end
    cyc();
    jump_c_i = 1'b0;
    pipe_stall_i = 1'b0;
    pc_i = 32'h200;
    #1;
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL js_req act=%0h exp=1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h200) begin errors++; $display("FAIL js_addr act=%0h exp=200", imem_addr_o); end
  endtask

  task automatic test_reset_mid();
    imem_gnt_i = 1'b1;
    cyc();
    imem_gnt_i = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hBAD0_BAD0;
    pc_i = 32'h0;
    #1;
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rm_valid act=%0h exp=0", instr_valid_o); end
    checks++; if (instruction_o !== NOP) begin errors++; $display("FAIL rm_instr act=%0h exp=%0h", instruction_o, NOP); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rm_req act=%0h exp=0", imem_req_o); end
    checks++; if (stall_cnt_o !== 32'h0) begin errors++; $display("FAIL rm_cnt act=%0d exp=0", stall_cnt_o); end
    cyc();
    imem_rvalid_i = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL rm_next req=%0h addr=%0h exp req=1 addr=0", imem_req_o, imem_addr_o); end
    checks++; if (stall_cnt_o !== 32'd1) begin errors++; $display("FAIL rm_cnt1 act=%0d exp=1", stall_cnt_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    pc_i = 32'h0;
    pipe_stall_i = 1'b0;
    jump_c_i = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
    test_reset();
    test_zero_wait();
    test_gnt_delay();
    test_jump_wait();
    test_hold();
    test_jump_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
